// File: rtl/fetch_unit.sv
// RV32I fetch front end: credit-limited in-order imem requests, prefetch FIFO
// towards decode, and redirect handling that discards stale in-flight words.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic [6:0]  op_o,
  output logic [2:0]  funct3_o,
  output logic        funct7_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [31:0]   PC0     = {RESET_PC[31:2], 2'b00};

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t        mem [FIFO_DEPTH];
  entry_t        head;
  logic [31:0]   fetch_pc, rsp_pc, redir_pc;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, inflight, inflight_nxt, drop;
  logic [CW:0]   credit;
  logic          req_fire, discard, push, pop;

  // Credits cover both in-flight and buffered words, so the FIFO never overflows.
  assign credit           = {1'b0, inflight} + {1'b0, count};
  assign imem_req_valid_o = !rst_i && !redirect_i && (credit < DEPTH_C);
  assign imem_req_addr_o  = fetch_pc;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;

  assign discard  = (drop != '0) || redirect_i;
  assign push     = imem_rsp_valid_i && !discard;
  assign redir_pc = {redirect_pc_i[31:2], 2'b00};

  assign instr_valid_o = (count != '0);
  assign pop           = instr_valid_o && instr_ready_i;

  // Stale storage is never exposed: outputs read zero whenever the FIFO is empty.
  assign head       = mem[rd_ptr];
  assign instr_o    = instr_valid_o ? head.instr : '0;
  assign instr_pc_o = instr_valid_o ? head.pc    : '0;
  assign op_o       = instr_o[6:0];
  assign funct3_o   = instr_o[14:12];
  assign funct7_o   = instr_o[30];

  always_comb begin
    inflight_nxt = inflight;
    if (req_fire && !imem_rsp_valid_i)      inflight_nxt = inflight + CW'(1);
    else if (!req_fire && imem_rsp_valid_i) inflight_nxt = inflight - CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc <= PC0;
      rsp_pc   <= PC0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (redirect_i) begin
        // No request fires in a redirect cycle, so inflight_nxt is the post-response count.
        fetch_pc <= redir_pc;
        rsp_pc   <= redir_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        drop     <= inflight_nxt;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
          rsp_pc <= rsp_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (!push && pop) count <= count - CW'(1);
        if (imem_rsp_valid_i && drop != '0) drop <= drop - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= '{instr: imem_rsp_data_i, pc: rsp_pc};
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural imem with programmable latency,
// handshake log on the decode side, hand-computed expected PCs and fields.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int lat   = 1;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic [6:0] op; logic [2:0] f3; logic f7; } hs_t;

  pend_t       pq[$];
  logic [31:0] acc_q[$];
  hs_t         got[$];

  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready), .imem_req_addr_o(req_addr),
    .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .instr_o(instr), .instr_pc_o(instr_pc),
    .op_o(op), .funct3_o(funct3), .funct7_o(funct7)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h4000_0033;
      default: return {a[24:0], 7'h13};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, obs, exp);
    end
  endtask

  // Pre-edge sampling of accepted requests and decode handshakes.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && req_valid && req_ready) begin
      pq.push_back('{addr: req_addr, due: cyc + lat});
      acc_q.push_back(req_addr);
    end
    if (!rst && instr_valid && instr_ready)
      got.push_back('{pc: instr_pc, instr: instr, op: op, f3: funct3, f7: funct7});
  end

  initial begin
    rsp_valid = 1'b0;
    rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pq.delete();
        rsp_valid = 1'b0;
      end else if (pq.size() > 0 && pq[0].due <= cyc) begin
        rsp_valid = 1'b1;
        rsp_data  = word_at(pq[0].addr);
        void'(pq.pop_front());
      end else begin
        rsp_valid = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect = 1'b0;
    repeat (2) @(negedge clk);
    got.delete();
    acc_q.delete();
    rst = 1'b0;
  endtask

  task automatic wait_got(input int n, input int bound);
    int i = 0;
    while (got.size() < n && i < bound) begin
      @(negedge clk);
      i++;
    end
    chk("wait_hs", 32'(got.size() >= n), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_ready = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    chk("rst_addr", req_addr, 32'h0);

    // 1: basic stream, latency 1, decode always ready
    lat = 1; instr_ready = 1'b1;
    do_reset();
    wait_got(3, 20);
    chk("t1_acc0", acc_q[0], 32'h0);
    for (int k = 0; k < 3; k++) chk("t1_pc", got[k].pc, 32'(4 * k));
    chk("t1_w0", got[0].instr, 32'h0050_0093);
    chk("t1_op0", 32'(got[0].op), 32'h13);
    chk("t1_f3_0", 32'(got[0].f3), 32'h0);
    chk("t1_op1", 32'(got[1].op), 32'h33);
    chk("t1_f7_1", 32'(got[1].f7), 32'h1);

    // 2: decode backpressure fills the FIFO and stops requests
    instr_ready = 1'b0;
    do_reset();
    repeat (10) @(negedge clk);
    chk("t2_acc_cnt", 32'(acc_q.size()), 32'd2);
    chk("t2_req_valid", 32'(req_valid), 32'd0);
    chk("t2_instr_valid", 32'(instr_valid), 32'd1);
    chk("t2_head_pc", instr_pc, 32'h0);
    chk("t2_head_w", instr, word_at(32'h0));
    instr_ready = 1'b1;
    wait_got(4, 30);
    for (int k = 0; k < 4; k++) begin
      chk("t2_pc", got[k].pc, 32'(4 * k));
      chk("t2_w", got[k].instr, word_at(32'(4 * k)));
    end

    // 3: redirect with two responses outstanding, latency 3
    lat = 3;
    do_reset();
    repeat (2) @(negedge clk);
    chk("t3_acc_cnt", 32'(acc_q.size()), 32'd2);
    chk("t3_req_valid", 32'(req_valid), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 1'b0;
    wait_got(1, 30);
    chk("t3_pc", got[0].pc, 32'h100);
    chk("t3_w", got[0].instr, word_at(32'h100));
    chk("t3_acc2", acc_q[2], 32'h100);

    // 4: misaligned redirect coinciding with a response and a pop
    lat = 1;
    do_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("t4_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t4_instr_valid", 32'(instr_valid), 32'd1);
    chk("t4_head_pc", instr_pc, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h203;
    @(negedge clk);
    redirect = 1'b0;
    chk("t4_addr", req_addr, 32'h200);
    chk("t4_empty", 32'(instr_valid), 32'd0);
    chk("t4_hs_cnt", 32'(got.size()), 32'd1);
    wait_got(2, 20);
    chk("t4_pc", got[1].pc, 32'h200);
    chk("t4_w", got[1].instr, word_at(32'h200));

    // 5: imem request stall holds valid and address
    do_reset();
    for (int i = 0; i < 20 && acc_q.size() < 2; i++) @(negedge clk);
    req_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("t5_valid", 32'(req_valid), 32'd1);
      chk("t5_addr", req_addr, 32'h8);
      @(negedge clk);
    end
    req_ready = 1'b1;
    wait_got(3, 20);
    chk("t5_pc2", got[2].pc, 32'h8);
    chk("t5_acc2", acc_q[2], 32'h8);

    // 6: asynchronous reset with a full FIFO
    instr_ready = 1'b0;
    do_reset();
    repeat (6) @(negedge clk);
    chk("t6_full_valid", 32'(instr_valid), 32'd1);
    chk("t6_full_req", 32'(req_valid), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_valid", 32'(instr_valid), 32'd0);
    chk("t6_async_instr", instr, 32'd0);
    chk("t6_async_pc", instr_pc, 32'd0);
    chk("t6_async_op", 32'(op), 32'd0);
    repeat (2) @(negedge clk);
    got.delete();
    acc_q.delete();
    rst = 1'b0;
    #1;
    chk("t6_req_valid", 32'(req_valid), 32'd1);
    chk("t6_addr", req_addr, 32'h0);
    @(negedge clk);
    chk("t6_acc0", acc_q[0], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
